// File: rtl/param_register_file_pkg.sv
// -----------------------------------------------------------------------------
// param_register_file_pkg
// Shared definitions for the parametrised register file: sweep FSM state
// encodings and the default datapath widths used by the CPU core.
// -----------------------------------------------------------------------------
package param_register_file_pkg;

  // Sweep-clear FSM encodings (one bit is enough for two states)
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // Defaults shared with the datapath
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;

endpackage : param_register_file_pkg

// File: rtl/param_register_file_sweeper.sv
// -----------------------------------------------------------------------------
// rf_clear_sweeper
// Sequential clear engine. A ClearReq seen in IDLE starts a walk over every
// register address, one per cycle, starting at 0. Requests arriving during a
// walk are ignored.
// Ports:
//   clk        in   clock, rising edge
//   startin    in   synchronous active-high reset
//   clear_req  in   start a sweep (pulse or level)
//   busy       out  high exactly while sweeping
//   sweep_en   out  zero register/pending bit at sweep_addr this cycle
//   sweep_addr out  address being cleared this cycle
// -----------------------------------------------------------------------------
module rf_clear_sweeper
  import param_register_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              clear_req,
  output logic              busy,
  output logic              sweep_en,
  output logic [ADDR_W-1:0] sweep_addr
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next-state and counter logic for the sweep walk
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_SWEEP;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        // Counter wraps back to 0 after the last address
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SWEEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and counter flops with synchronous reset
  always_ff @(posedge clk) begin
    if (startin) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come straight from flops
  assign busy       = (state_q == ST_SWEEP);
  assign sweep_en   = (state_q == ST_SWEEP);
  assign sweep_addr = cnt_q;

endmodule : rf_clear_sweeper

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
// Register file with two combinational read ports, two prioritised write
// ports (B beats A), optional write-through bypass, optional hardwired zero
// register, a per-register pending scoreboard, a sweep-clear engine and a
// non-bypassed debug read port.
// Ports:
//   clk, startin                       clock / sync active-high reset
//   Read1/Read2 -> Data1/Data2         read ports, Pending1/Pending2 pending bits
//   WriteReg/WriteData/RegWrite        write port A
//   WriteReg2/WriteData2/RegWrite2     write port B (wins on same address)
//   Reserve/ReserveReg                 set pending bit
//   ClearReq -> Busy                   sweep-clear start / in progress
//   regNo -> val                       debug read of stored value
// -----------------------------------------------------------------------------
module param_register_file
  import param_register_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              startin,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic [WIDTH-1:0]  Data1,
  output logic [WIDTH-1:0]  Data2,
  output logic              Pending1,
  output logic              Pending2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg2,
  input  logic [WIDTH-1:0]  WriteData2,
  input  logic              RegWrite2,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveReg,
  input  logic              ClearReq,
  output logic              Busy,
  input  logic [ADDR_W-1:0] regNo,
  output logic [WIDTH-1:0]  val
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  logic              busy_s;
  logic              sweep_en_s;
  logic [ADDR_W-1:0] sweep_addr_s;
  logic              we_a_s, we_b_s, rsv_s;

  rf_clear_sweeper #(.ADDR_W(ADDR_W)) u_sweeper (
    .clk        (clk),
    .startin    (startin),
    .clear_req  (ClearReq),
    .busy       (busy_s),
    .sweep_en   (sweep_en_s),
    .sweep_addr (sweep_addr_s)
  );

  assign Busy = busy_s;

  // Qualified write/reserve enables: nothing lands while sweeping or on r0
  always_comb begin
    we_a_s = RegWrite  && !busy_s && !((ZERO_REG != 0) && (WriteReg   == ADDR_ZERO));
    we_b_s = RegWrite2 && !busy_s && !((ZERO_REG != 0) && (WriteReg2  == ADDR_ZERO));
    rsv_s  = Reserve   && !busy_s && !((ZERO_REG != 0) && (ReserveReg == ADDR_ZERO));
  end

  // Next array and scoreboard state; later assignments take priority
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (sweep_en_s) begin
      mem_d[sweep_addr_s]  = {WIDTH{1'b0}};
      pend_d[sweep_addr_s] = 1'b0;
    end else begin
      if (we_a_s) begin
        mem_d[WriteReg]  = WriteData;
        pend_d[WriteReg] = 1'b0;
      end else begin
        mem_d[0] = mem_d[0];
      end
      // Port B after port A so B wins on a shared address
      if (we_b_s) begin
        mem_d[WriteReg2]  = WriteData2;
        pend_d[WriteReg2] = 1'b0;
      end else begin
        mem_d[0] = mem_d[0];
      end
      // Reserve after the clears so set beats clear
      if (rsv_s) begin
        pend_d[ReserveReg] = 1'b1;
      end else begin
        pend_d[0] = pend_d[0];
      end
    end
  end

  // Array and pending flops with synchronous reset
  always_ff @(posedge clk) begin
    if (startin) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      pend_q <= {DEPTH{1'b0}};
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  // Read port 1: zero register, then bypass (B before A), then array
  always_comb begin
    if ((ZERO_REG != 0) && (Read1 == ADDR_ZERO)) begin
      Data1    = {WIDTH{1'b0}};
      Pending1 = 1'b0;
    end else begin
      Pending1 = pend_q[Read1];
      if ((BYPASS != 0) && !busy_s && RegWrite2 && (WriteReg2 == Read1)) begin
        Data1 = WriteData2;
      end else if ((BYPASS != 0) && !busy_s && RegWrite && (WriteReg == Read1)) begin
        Data1 = WriteData;
      end else begin
        Data1 = mem_q[Read1];
      end
    end
  end

  // Read port 2: same structure as port 1
  always_comb begin
    if ((ZERO_REG != 0) && (Read2 == ADDR_ZERO)) begin
      Data2    = {WIDTH{1'b0}};
      Pending2 = 1'b0;
    end else begin
      Pending2 = pend_q[Read2];
      if ((BYPASS != 0) && !busy_s && RegWrite2 && (WriteReg2 == Read2)) begin
        Data2 = WriteData2;
      end else if ((BYPASS != 0) && !busy_s && RegWrite && (WriteReg == Read2)) begin
        Data2 = WriteData;
      end else begin
        Data2 = mem_q[Read2];
      end
    end
  end

  // Debug port shows the stored value only
  assign val = mem_q[regNo];

endmodule : param_register_file
